data_path: RTL
==============

# data_path

K&S processor datapath: holds the program counter, instruction register, 4-entry register file, ALU and flags register, and drives the RAM address and write data. It decodes the instruction register into `decoded_instruction` for `control_unit`. It executes only under that unit's enable and select strobes, and returns registered ALU flags for its branch decisions.

## Interface
- `DATA_W`, 16, word width of registers, ALU, RAM data and instruction.
- `ADDR_W`, 5, RAM address width; PC width.
- Reset `rst_n`, asynchronous, active-low; clock `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `ir_enable`  in  1  load IR from `data_in`
- `pc_enable`  in  1  update PC
- `branch`  in  1  with `pc_enable`: PC <= IR address field, else PC+1
- `addr_sel`  in  1  0: `ram_addr`=PC; 1: `ram_addr`=IR[ADDR_W-1:0]
- `c_sel`  in  1  write-back source; 0: ALU result; 1: `data_in`
- `write_reg_enable`  in  1  write bus C into register `c_addr`
- `operation`  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
- `flags_reg_enable`  in  1  capture ALU flags
- `data_in`  in  DATA_W  RAM read data
- `ram_addr`  out  ADDR_W  RAM address (combinational)
- `data_out`  out  DATA_W  RAM write data = bus A (combinational)
- `decoded_instruction`  out  `decoded_instruction_type`  decode of IR (combinational)
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow`  out  1 each  registered flags

## Operation
- Reset: PC=0, IR=0 (decodes I_NOP), R0..R3=0, all flags 0.
- Opcode is IR[15:8]:
  - 0x00 NOP, 0x81 LOAD, 0x82 STORE, 0x91 MOVE
  - 0xA1 ADD, 0xA2 SUB, 0xA3 AND, 0xA4 OR
  - 0x01 BRANCH, 0x02 BZERO, 0x03 BNZERO, 0x04 BNEG, 0x05 BNNEG, 0x06 BOV, 0x07 BNOV
  - 0xFF HALT
  - Any other opcode: I_NOP.
- Register fields (unlisted fields are 0):
  - LOAD: `c_addr`=IR[6:5].
  - STORE: `a_addr`=IR[6:5].
  - MOVE: `c_addr`=IR[3:2], `a_addr`=`b_addr`=IR[1:0]; the control unit selects OR, so the result equals A.
  - ALU ops: `c_addr`=IR[5:4], `a_addr`=IR[3:2], `b_addr`=IR[1:0].
- Memory address field is IR[ADDR_W-1:0]. This applies to LOAD, STORE and all branches.
- PC: on `pc_enable`, `branch`=1 loads the address field of the current IR; `branch`=0 does PC+1, wrapping 2^ADDR_W-1 -> 0.
- ALU and flags:
  - ADD/SUB are computed in DATA_W+1 bits.
  - `unsigned_overflow`: carry out for ADD; borrow (A<B unsigned) for SUB.
  - `signed_overflow`: operand signs equal (ADD) or differ (SUB), and the result sign differs from A.
  - AND/OR clear both overflow flags.
  - zero = result==0; neg = result[DATA_W-1].
- Register file reads are asynchronous and writes are synchronous. A read of the register being written returns the old value in that cycle.

## Timing
- All state (PC, IR, registers, flags) updates at posedge `clk` only.
- `decoded_instruction` is valid the cycle after the `ir_enable` edge.
- `ir_enable` and `pc_enable` in the same cycle: IR captures the word at the old PC; PC then advances.
- `branch` with `pc_enable` uses the IR value present before the edge.
- Flags are visible the cycle after `flags_reg_enable`. They hold otherwise, including across branches and loads.
- `ram_addr`, `data_out` and the C-bus mux are same-cycle combinational; RAM read latency is owned by the control unit (LOAD_1/LOAD_2).
- Reset asserted mid-instruction returns all state to reset values immediately, regardless of enables.

## Configuration
- `KS_DP_HALT_ON_ILLEGAL_EN` defined: undefined opcodes decode to I_HALT.
- Not defined: undefined opcodes decode to I_NOP.

## Structure
- `k_and_s_pkg` holds:
  - `decoded_instruction_type` enum: I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT.
  - Opcode localparams.
  - ALU operation constants.
- One sub-module, `ks_alu`: combinational result plus the four flags, parameterised by DATA_W.

## Test plan
- Reset release -> `ram_addr`=0, all flags 0, `decoded_instruction`=I_NOP; `ir_enable`+`pc_enable` with `data_in`=0x8163 -> IR=0x8163, PC=1, decode I_LOAD, `ram_addr`=0x03 when `addr_sel`=1.
- LOAD then write with `c_sel`=1, `data_in`=0x1234 -> R3=0x1234; STORE 0x8263 with `addr_sel`=1 -> `data_out`=0x1234, `ram_addr`=0x03.
- R1=0x7FFF, R2=0x0001, ADD 0xA106 (`c_addr`=0, A=R1, B=R2) with flags enable -> R0=0x8000; flags neg=1, signed_ovf=1, unsigned_ovf=0, zero=0.
- SUB with R1=R2=0x0005 -> result 0, zero=1, unsigned_ovf=0; SUB 0x0003-0x0005 -> 0xFFFE, unsigned_ovf=1, neg=1.
- PC=31, `pc_enable`, `branch`=0 -> PC=0; IR=0x0111 with `pc_enable`+`branch` -> PC=0x11.
- Opcode 0x55 -> I_NOP without macro, I_HALT with `KS_DP_HALT_ON_ILLEGAL_EN`; `rst_n` pulsed mid-ADD -> all registers and flags 0.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types and constants for the K&S processor datapath.
//   decoded_instruction_type : decode result handed to the control unit
//   OPC_*                    : opcode values found in IR[15:8]
//   ALU_*                    : ALU operation select encodings
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_BOV,
        I_BNOV,
        I_HALT
    } decoded_instruction_type;

    localparam logic [7:0] OPC_NOP    = 8'h00;
    localparam logic [7:0] OPC_LOAD   = 8'h81;
    localparam logic [7:0] OPC_STORE  = 8'h82;
    localparam logic [7:0] OPC_MOVE   = 8'h91;
    localparam logic [7:0] OPC_ADD    = 8'hA1;
    localparam logic [7:0] OPC_SUB    = 8'hA2;
    localparam logic [7:0] OPC_AND    = 8'hA3;
    localparam logic [7:0] OPC_OR     = 8'hA4;
    localparam logic [7:0] OPC_BRANCH = 8'h01;
    localparam logic [7:0] OPC_BZERO  = 8'h02;
    localparam logic [7:0] OPC_BNZERO = 8'h03;
    localparam logic [7:0] OPC_BNEG   = 8'h04;
    localparam logic [7:0] OPC_BNNEG  = 8'h05;
    localparam logic [7:0] OPC_BOV    = 8'h06;
    localparam logic [7:0] OPC_BNOV   = 8'h07;
    localparam logic [7:0] OPC_HALT   = 8'hFF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/ks_alu.sv
// ks_alu: combinational ALU for the K&S datapath.
//   a, b              : operands (DATA_W)
//   operation         : ALU_ADD / ALU_SUB / ALU_AND / ALU_OR
//   result            : operation result (DATA_W)
//   zero, neg         : result == 0, result sign bit
//   unsigned_overflow : carry out (ADD) or borrow (SUB); 0 for logic ops
//   signed_overflow   : two's-complement overflow; 0 for logic ops
module ks_alu
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        operation,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              neg,
    output logic              unsigned_overflow,
    output logic              signed_overflow
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] wide;

    always_comb begin
        wide              = '0;
        result            = '0;
        unsigned_overflow = 1'b0;
        signed_overflow   = 1'b0;
        case (operation)
            ALU_ADD: begin
                wide              = {1'b0, a} + {1'b0, b};
                result            = wide[MSB:0];
                unsigned_overflow = wide[DATA_W];
                signed_overflow   = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                // The extra bit of a zero-extended subtraction is the borrow (a < b).
                wide              = {1'b0, a} - {1'b0, b};
                result            = wide[MSB:0];
                unsigned_overflow = wide[DATA_W];
                signed_overflow   = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            default: result = a | b;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[MSB];

endmodule

// File: rtl/data_path.sv
// data_path: K&S processor datapath (PC, IR, 4-entry register file, ALU, flags).
// Optional build macro: KS_DP_HALT_ON_ILLEGAL_EN -- undefined opcodes decode to
// I_HALT instead of I_NOP.
//   ir_enable / pc_enable / branch : IR load, PC update, PC branch-vs-increment
//   addr_sel                       : ram_addr source, 0 = PC, 1 = IR address field
//   c_sel / write_reg_enable       : write-back source (0 ALU, 1 data_in) and strobe
//   operation / flags_reg_enable   : ALU op select and flag capture strobe
//   data_in                        : RAM read data
//   ram_addr, data_out             : RAM address and write data (bus A), combinational
//   decoded_instruction            : combinational decode of IR
//   zero_op, neg_op, unsigned_overflow, signed_overflow : registered ALU flags
module data_path
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ir_enable,
    input  logic                    pc_enable,
    input  logic                    branch,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic                    write_reg_enable,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    input  logic [DATA_W-1:0]       data_in,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow
);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [4];

    logic [1:0]        a_addr, b_addr, c_addr;
    logic [DATA_W-1:0] bus_a, bus_b, bus_c, alu_result;
    logic              alu_zero, alu_neg, alu_uov, alu_sov;
    logic [7:0]        opcode;

    assign opcode = ir[15:8];

    always_comb begin
        decoded_instruction = I_NOP;
        a_addr              = 2'd0;
        b_addr              = 2'd0;
        c_addr              = 2'd0;
        case (opcode)
            OPC_NOP:    decoded_instruction = I_NOP;
            OPC_LOAD: begin
                decoded_instruction = I_LOAD;
                c_addr              = ir[6:5];
            end
            OPC_STORE: begin
                decoded_instruction = I_STORE;
                a_addr              = ir[6:5];
            end
            OPC_MOVE: begin
                decoded_instruction = I_MOVE;
                c_addr              = ir[3:2];
                a_addr              = ir[1:0];
                b_addr              = ir[1:0];
            end
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
                case (opcode)
                    OPC_ADD: decoded_instruction = I_ADD;
                    OPC_SUB: decoded_instruction = I_SUB;
                    OPC_AND: decoded_instruction = I_AND;
                    default: decoded_instruction = I_OR;
                endcase
                c_addr = ir[5:4];
                a_addr = ir[3:2];
                b_addr = ir[1:0];
            end
            OPC_BRANCH: decoded_instruction = I_BRANCH;
            OPC_BZERO:  decoded_instruction = I_BZERO;
            OPC_BNZERO: decoded_instruction = I_BNZERO;
            OPC_BNEG:   decoded_instruction = I_BNEG;
            OPC_BNNEG:  decoded_instruction = I_BNNEG;
            OPC_BOV:    decoded_instruction = I_BOV;
            OPC_BNOV:   decoded_instruction = I_BNOV;
            OPC_HALT:   decoded_instruction = I_HALT;
            default: begin
`ifdef KS_DP_HALT_ON_ILLEGAL_EN
                decoded_instruction = I_HALT;
`else
                decoded_instruction = I_NOP;
`endif
            end
        endcase
    end

    // Asynchronous reads: a register being written this cycle still reads its old value.
    assign bus_a    = regs[a_addr];
    assign bus_b    = regs[b_addr];
    assign bus_c    = c_sel ? data_in : alu_result;
    assign data_out = bus_a;
    assign ram_addr = addr_sel ? ir[ADDR_W-1:0] : pc;

    ks_alu #(.DATA_W(DATA_W)) u_alu (
        .a                 (bus_a),
        .b                 (bus_b),
        .operation         (operation),
        .result            (alu_result),
        .zero              (alu_zero),
        .neg               (alu_neg),
        .unsigned_overflow (alu_uov),
        .signed_overflow   (alu_sov)
    );

    // Branch target comes from the IR value before this edge, so a combined
    // ir_enable + pc_enable + branch uses the previous instruction's address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (ir_enable)
                ir <= data_in;
            if (pc_enable)
                pc <= branch ? ir[ADDR_W-1:0] : pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else if (write_reg_enable) begin
            regs[c_addr] <= bus_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= alu_zero;
            neg_op            <= alu_neg;
            unsigned_overflow <= alu_uov;
            signed_overflow   <= alu_sov;
        end
    end

endmodule
